// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: detects the start edge, walks start/data/parity/stop bits with an
// oversample edge counter and a data bit counter, strobes the datapath checkers at the
// sampling point of each bit, and qualifies the frame with data_valid or rx_err.
module uart_rx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESC_W    = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               PAR_EN,
  input  logic               strt_glitch,
  input  logic               par_err,
  input  logic               stp_err,
  output logic               dat_samp_en,
  output logic               strt_chk_en,
  output logic               par_chk_en,
  output logic               stp_chk_en,
  output logic               deser_en,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic               busy,
  output logic               data_valid,
  output logic               rx_err
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  localparam logic [PRESC_W-1:0] PrescDefault = PRESC_W'(8);
  localparam logic [3:0]         LastBit      = 4'(DATA_WIDTH - 1);

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] edge_q, edge_d;
  logic [3:0]         bit_q, bit_d;
  logic [PRESC_W-1:0] p_q, p_d;
  logic               pe_q, pe_d;
  logic               busy_q, busy_d;
  logic               strt_q, strt_d;
  logic               deser_q, deser_d;
  logic               par_q, par_d;
  logic               stp_q, stp_d;
  logic               dv_q, dv_d;
  logic               err_q, err_d;

  logic               bit_end;
  logic               presc_legal;
  logic [PRESC_W-1:0] chk_d;

  assign bit_end     = (edge_q == p_q - PRESC_W'(1));
  assign presc_legal = (prescale == PRESC_W'(8)) || (prescale == PRESC_W'(16)) ||
                       (prescale == PRESC_W'(32));

  // Next-state, counters, config latch and the next value of every registered output.
  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    bit_d   = bit_q;
    p_d     = p_q;
    pe_d    = pe_q;
    dv_d    = 1'b0;
    err_d   = 1'b0;

    if (state_q != StIdle) begin
      edge_d = bit_end ? '0 : edge_q + PRESC_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        edge_d = '0;
        bit_d  = '0;
        if (!RX_IN) begin
          // The detect cycle is edge 0 of the start bit.
          state_d = StStart;
          edge_d  = PRESC_W'(1);
          p_d     = presc_legal ? prescale : PrescDefault;
          pe_d    = PAR_EN;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = strt_glitch ? StIdle : StData;
          bit_d   = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == LastBit) begin
            state_d = pe_q ? StParity : StStop;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
          if (!stp_err && (!pe_q || !par_err)) dv_d = 1'b1;
          else                                 err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Strobes are derived from the next state so they line up with the registered edge_cnt.
    chk_d   = (p_d >> 1) + PRESC_W'(2);
    busy_d  = (state_d != StIdle);
    strt_d  = (state_d == StStart)  && (edge_d == chk_d);
    deser_d = (state_d == StData)   && (edge_d == chk_d);
    par_d   = (state_d == StParity) && (edge_d == chk_d);
    stp_d   = (state_d == StStop)   && (edge_d == chk_d);
  end

  // State, counters, latched config and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      edge_q  <= '0;
      bit_q   <= '0;
      p_q     <= PrescDefault;
      pe_q    <= 1'b0;
      busy_q  <= 1'b0;
      strt_q  <= 1'b0;
      deser_q <= 1'b0;
      par_q   <= 1'b0;
      stp_q   <= 1'b0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      p_q     <= p_d;
      pe_q    <= pe_d;
      busy_q  <= busy_d;
      strt_q  <= strt_d;
      deser_q <= deser_d;
      par_q   <= par_d;
      stp_q   <= stp_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
    end
  end

  assign dat_samp_en = busy_q;
  assign busy        = busy_q;
  assign strt_chk_en = strt_q;
  assign deser_en    = deser_q;
  assign par_chk_en  = par_q;
  assign stp_chk_en  = stp_q;
  assign data_valid  = dv_q;
  assign rx_err      = err_q;
  assign edge_cnt    = edge_q;
  assign bit_cnt     = bit_q;

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side sequencer for the UART RX path.
- Detects a falling edge on RX_IN and walks the frame through start, data, optional parity and stop bits, using an integrated edge/bit counter.
- Issues one-cycle enables to the data sampler, start-check, parity-check, stop-check and deserializer blocks, then qualifies the frame with data_valid or rx_err.
- Sits between the oversampling clock domain logic and the RX datapath checkers.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (1..15)
PRESC_W, 6, width of prescale and edge_cnt

Ports:
CLK  in  1  oversampling clock (prescale ticks per bit)
RST  in  1  asynchronous, active-low reset
RX_IN  in  1  serial line, idle high
prescale  in  PRESC_W  oversampling ratio; legal values 8, 16, 32
PAR_EN  in  1  parity bit present in frame
strt_glitch  in  1  registered start-check result, 1 = false start
par_err  in  1  registered parity-check result
stp_err  in  1  registered stop-check result
dat_samp_en  out  1  data sampler enable
strt_chk_en  out  1  start-check capture strobe
par_chk_en  out  1  parity-check capture strobe
stp_chk_en  out  1  stop-check capture strobe
deser_en  out  1  deserializer shift strobe
edge_cnt  out  PRESC_W  oversample position within current bit
bit_cnt  out  4  data bit index 0..DATA_WIDTH-1
busy  out  1  frame in progress
data_valid  out  1  one-cycle pulse, frame accepted
rx_err  out  1  one-cycle pulse, frame dropped due to parity or stop error

Behaviour:
- Reset: all outputs 0; state IDLE; edge_cnt=0; bit_cnt=0; latched config cleared (P=8, PE=0).
- Config latch:
  - In IDLE, on the start-detect cycle, prescale is latched to P and PAR_EN to PE.
  - Mid-frame changes to prescale or PAR_EN are ignored.
  - Illegal prescale values (anything other than 8, 16 or 32) latch as P=8.
- States: IDLE, START, DATA, PARITY, STOP. All are registered (Moore) with registered outputs.
- IDLE:
  - edge_cnt=0, busy=0.
  - RX_IN==0 → START. The detect cycle counts as edge 0, so the first START cycle shows edge_cnt=1.
- Edge counter:
  - In non-IDLE states, counts 0..P-1 and wraps to 0.
  - Bit end E = (edge_cnt==P-1).
- Check point C = P/2+2 (sampler majority result valid here).
- Strobes are single-cycle, asserted during the cycle edge_cnt==C:
  - strt_chk_en in START.
  - deser_en in DATA.
  - par_chk_en in PARITY.
  - stp_chk_en in STOP.
- dat_samp_en=1 in every non-IDLE state.
- START at E:
  - strt_glitch=1 → IDLE, no further strobes.
  - strt_glitch=0 → DATA with bit_cnt=0.
- DATA at E:
  - If bit_cnt==DATA_WIDTH-1: go to PARITY if PE=1, else STOP; bit_cnt→0.
  - Otherwise bit_cnt+1.
- PARITY at E → STOP.
- STOP at E → IDLE. On the next cycle:
  - data_valid=1 if stp_err==0 and (PE==0 or par_err==0).
  - Otherwise rx_err=1.
  - data_valid and rx_err are never high together.
- busy=1 from the first START cycle through the STOP-E cycle.
- Back-to-back frames: the IDLE cycle after STOP can itself be a start-detect cycle (RX_IN low).
- Frame length: (1+DATA_WIDTH+PE+1)*P cycles, from the detect cycle to the STOP-E cycle inclusive.
- Reset mid-frame: immediate return to IDLE with all outputs 0; no data_valid or rx_err.
- RX_IN transitions during START/DATA/PARITY/STOP do not affect sequencing; only the checker results do.

Test Plan:
- Reset with RX_IN=1 → all outputs 0, busy=0; stays IDLE for 100 cycles.
- prescale=8, PAR_EN=1, even-parity frame 0xA5, checkers return 0 → exactly 8 deser_en pulses at edge_cnt=6 (bit_cnt 0..7), one par_chk_en, one stp_chk_en, data_valid 1 cycle exactly 88 cycles after the detect cycle, rx_err=0.
- prescale=16, PAR_EN=0, frame 0x3C → strobes at edge_cnt=10, no par_chk_en, data_valid 160 cycles after detect.
- RX_IN low 3 cycles then high, strt_glitch driven 1 → strt_chk_en once, no deser_en, busy falls 8 cycles after detect, no data_valid or rx_err.
- prescale=8, PAR_EN=1, par_err=1 at check → rx_err pulse at cycle 88, data_valid stays 0. Repeat with stp_err=1 and PAR_EN=0 → rx_err at cycle 80.
- prescale changed 8→32 mid-frame → frame still completes at 88 cycles. Assert RST low during DATA bit 3 → all outputs 0 immediately, next frame decodes correctly.
